// File: rtl/param_reg_file.sv
// Parametrised multi-port register file with combinational driven read ports,
// write-to-read bypass, optional hardwired-zero R0 and a sequential bulk-clear engine.
module param_reg_file #(
    parameter  int WIDTH     = 16,
    parameter  int DEPTH     = 16,
    parameter  int NUM_RD    = 2,
    parameter  int ZERO_REG0 = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    wr_drop
);

    // state | meaning
    // IDLE  | normal operation: writes, bypass, clear request accepted
    // CLEAR | zeroing mem[cnt] one entry per cycle; writes dropped, no bypass
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [AW-1:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                wr_ok;
    logic                r0_hit;
    logic [AW-1:0]       ra;

    assign r0_hit   = (ZERO_REG0 != 0) && (wr_addr == '0);
    assign wr_ok    = wr_en && (state == IDLE) && !r0_hit;
    assign clr_busy = (state == CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr_drop <= wr_en && (state == CLEAR);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear and write never coincide: writes are only accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((state == CLEAR) && (cnt == AW'(i)))
                    mem[i] <= '0;
                else if (wr_ok && (wr_addr == AW'(i)))
                    mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (rd_en[p] && !((ZERO_REG0 != 0) && (ra == '0))) begin
                if ((state == IDLE) && wr_en && (wr_addr == ra))
                    rd_data[p*WIDTH +: WIDTH] = wr_data;
                else
                    rd_data[p*WIDTH +: WIDTH] = mem[ra];
            end
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: default 16x16x2 instance plus a 32x8x3 instance.
module tb_param_reg_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A: WIDTH 16, DEPTH 16, NUM_RD 2
    logic        wr_en_a = 1'b0;
    logic [3:0]  wr_addr_a = '0;
    logic [15:0] wr_data_a = '0;
    logic [1:0]  rd_en_a = '0;
    logic [7:0]  rd_addr_a = '0;
    logic [31:0] rd_data_a;
    logic        clr_req_a = 1'b0;
    logic        clr_busy_a, wr_drop_a;

    // instance B: WIDTH 32, DEPTH 8, NUM_RD 3
    logic        wr_en_b = 1'b0;
    logic [2:0]  wr_addr_b = '0;
    logic [31:0] wr_data_b = '0;
    logic [2:0]  rd_en_b = '0;
    logic [8:0]  rd_addr_b = '0;
    logic [95:0] rd_data_b;
    logic        clr_req_b = 1'b0;
    logic        clr_busy_b, wr_drop_b;

    param_reg_file dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .clr_req(clr_req_a), .clr_busy(clr_busy_a), .wr_drop(wr_drop_a)
    );

    param_reg_file #(.WIDTH(32), .DEPTH(8), .NUM_RD(3), .ZERO_REG0(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .clr_req(clr_req_b), .clr_busy(clr_busy_b), .wr_drop(wr_drop_b)
    );

    // sel: 0..1 A read port, 8 A busy, 9 A drop, 16..18 B read port, 24 B busy, 25 B drop
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        e;
    logic [31:0] act;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            act = '0;
            if (e.sel < 8)       act = {16'h0, rd_data_a[e.sel*16 +: 16]};
            else if (e.sel == 8) act = {31'h0, clr_busy_a};
            else if (e.sel == 9) act = {31'h0, wr_drop_a};
            else if (e.sel < 24) act = rd_data_b[(e.sel-16)*32 +: 32];
            else if (e.sel == 24) act = {31'h0, clr_busy_b};
            else                 act = {31'h0, wr_drop_b};
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic push(input string n, input int sel, input logic [31:0] x);
        exp_t t;
        t.name = n; t.sel = sel; t.exp = x;
        q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rda(input logic [1:0] en, input int a0, input int a1);
        rd_en_a   = en;
        rd_addr_a = {4'(a1), 4'(a0)};
    endtask

    task automatic wra(input logic en, input int a, input logic [15:0] d);
        wr_en_a = en; wr_addr_a = 4'(a); wr_data_a = d;
    endtask

    task automatic rdb(input logic [2:0] en, input int a0, input int a1, input int a2);
        rd_en_b   = en;
        rd_addr_b = {3'(a2), 3'(a1), 3'(a0)};
    endtask

    initial begin
        // 1: reset
        repeat (3) tick();
        push("busy_in_reset", 8, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            rda(2'b11, i, i + 8);
            push("reset_rd0", 0, 0);
            push("reset_rd1", 1, 0);
            push("reset_busy", 8, 0);
            push("reset_drop", 9, 0);
        end

        // 2: write / read
        tick(); rda(2'b00, 0, 0); wra(1, 5, 16'hBEEF);
        tick(); wra(0, 0, 0); rda(2'b01, 5, 5);
        push("rd_r5", 0, 32'hBEEF);
        push("rd_en1_off", 1, 0);
        tick(); rda(2'b10, 5, 5);
        push("rd_en0_off", 0, 0);
        push("rd1_r5", 1, 32'hBEEF);

        // 3: bypass and R0
        tick(); wra(1, 7, 16'h1234); rda(2'b11, 5, 7);
        push("bypass_r7", 1, 32'h1234);
        push("nobypass_r5", 0, 32'hBEEF);
        tick(); wra(1, 0, 16'hFFFF); rda(2'b11, 0, 7);
        push("r0_bypass", 0, 0);
        push("r7_committed", 1, 32'h1234);
        tick(); wra(0, 0, 0); rda(2'b11, 0, 0);
        push("r0_after_wr", 0, 0);
        push("r0_drop", 9, 0);

        // 4: bulk clear, with an ignored re-request at cycle 3
        for (int i = 1; i < 16; i++) begin
            tick(); wra(1, i, 16'h00FF);
        end
        tick(); wra(0, 0, 0); rda(2'b11, 1, 15);
        push("load_r1", 0, 32'h00FF);
        push("load_r15", 1, 32'h00FF);
        clr_req_a = 1'b1;
        push("busy_pre", 8, 0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            clr_req_a = (c == 3);
            push("clr_busy", 8, 1);
        end
        tick(); clr_req_a = 1'b0;
        push("clr_busy_end", 8, 0);
        for (int i = 0; i < 8; i++) begin
            tick(); rda(2'b11, i, i + 8);
            push("clr_rd0", 0, 0);
            push("clr_rd1", 1, 0);
            push("clr_no_restart", 8, 0);
        end

        // 5: write during clear
        tick(); wra(1, 3, 16'h1111);
        tick(); wra(0, 0, 0); clr_req_a = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick(); clr_req_a = 1'b0;
            if (c == 2) begin
                wra(1, 3, 16'hAAAA); rda(2'b01, 3, 0);
                push("clr_nobypass", 0, 32'h1111);
                push("drop_before", 9, 0);
            end else begin
                wra(0, 0, 0);
            end
            if (c == 3) push("drop_pulse", 9, 1);
            if (c == 4) push("drop_clear", 9, 0);
        end
        tick(); rda(2'b01, 3, 0);
        push("r3_after_clr", 0, 0);
        push("busy_after5", 8, 0);

        // 6: reset mid-clear
        tick(); wra(1, 2, 16'h7777);
        tick(); wra(1, 15, 16'h7777);
        tick(); wra(0, 0, 0); clr_req_a = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick(); clr_req_a = 1'b0;
        end
        tick(); rst = 1'b0; rda(2'b11, 2, 15);
        push("rst_busy", 8, 0);
        push("rst_r2", 0, 0);
        push("rst_r15", 1, 0);
        tick(); rst = 1'b1; wra(1, 2, 16'h5A5A); rda(2'b01, 2, 0);
        push("post_rst_bypass", 0, 32'h5A5A);
        tick(); wra(0, 0, 0); rda(2'b11, 2, 15);
        push("post_rst_r2", 0, 32'h5A5A);
        push("post_rst_r15", 1, 0);
        push("post_rst_busy", 8, 0);

        // instance B: 2-3 repeated plus a DEPTH=8 clear
        tick(); rda(2'b00, 0, 0); rdb(3'b111, 1, 4, 7);
        push("b_reset_rd0", 16, 0);
        push("b_reset_rd1", 17, 0);
        push("b_reset_rd2", 18, 0);
        tick(); rdb(3'b000, 0, 0, 0);
        wr_en_b = 1; wr_addr_b = 3'd5; wr_data_b = 32'hDEADBEEF;
        tick(); wr_en_b = 0; rdb(3'b011, 5, 5, 5);
        push("b_rd_r5", 16, 32'hDEADBEEF);
        push("b_rd1_r5", 17, 32'hDEADBEEF);
        push("b_en2_off", 18, 0);
        tick(); wr_en_b = 1; wr_addr_b = 3'd7; wr_data_b = 32'h12345678; rdb(3'b111, 0, 5, 7);
        push("b_bypass", 18, 32'h12345678);
        push("b_r5", 17, 32'hDEADBEEF);
        push("b_r0", 16, 0);
        tick(); wr_addr_b = 3'd0; wr_data_b = 32'hFFFFFFFF; rdb(3'b111, 0, 7, 0);
        push("b_r0_bypass", 16, 0);
        push("b_r0_bypass2", 18, 0);
        push("b_r7", 17, 32'h12345678);
        tick(); wr_en_b = 0; clr_req_b = 1'b1; rdb(3'b001, 0, 0, 0);
        push("b_r0_after", 16, 0);
        for (int c = 1; c <= 8; c++) begin
            tick(); clr_req_b = 1'b0;
            push("b_clr_busy", 24, 1);
        end
        tick(); rdb(3'b111, 5, 7, 5);
        push("b_clr_end", 24, 0);
        push("b_clr_r5", 16, 0);
        push("b_clr_r7", 17, 0);

        // drain scoreboard
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        tick();
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
